// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the transmit-side launch FSM states.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_fifo_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an explicit occupancy counter and synchronous clear.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap on their own because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue in front of the UART transmitter; launches one byte per frame using tx_busy pacing.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   clk_50m,
  input  logic                   rst_n,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic                   flush,
  output logic [UART_DATA_W-1:0] uart_din,
  output logic                   uart_wr_en,
  input  logic                   uart_tx_busy,
  output logic [AW:0]            count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   idle
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  tx_fifo_state_t         state;
  tx_fifo_state_t         state_next;
  logic [TW-1:0]          timer;
  logic [TW-1:0]          timer_next;
  logic                   launch_go;
  logic [UART_DATA_W-1:0] head;

  sync_fifo #(.WIDTH(UART_DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk_50m),
    .rst_n   (rst_n),
    .clear   (flush),
    .push    (wr_valid && !full && !flush),
    .pop     (launch_go),
    .wr_data (wr_data),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign wr_ready = !full;
  assign idle     = empty && (state == IDLE) && !uart_tx_busy;

  // A flush only blocks a fresh launch; a byte already handed over runs to completion.
  always_comb begin
    state_next = state;
    timer_next = timer;
    launch_go  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !uart_tx_busy && !flush) begin
          launch_go  = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        state_next = WAIT_BUSY;
        timer_next = TW'(BUSY_TIMEOUT);
      end
      WAIT_BUSY: begin
        if (uart_tx_busy) begin
          state_next = WAIT_DONE;
        end else begin
          timer_next = timer - 1'b1;
          if (timer <= TW'(1)) state_next = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      uart_wr_en <= 1'b0;
      uart_din   <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      uart_wr_en <= launch_go;
      if (launch_go) uart_din <= head;
      if (flush)
        overflow <= 1'b0;
      else if (wr_valid && full)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized and directed bench for uart_tx_fifo against a queue-based scoreboard and transmitter model.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk_50m = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          wr_valid = 1'b0;
  logic          flush = 1'b0;
  logic          uart_tx_busy = 1'b0;
  logic          wr_ready;
  logic [7:0]    uart_din;
  logic          uart_wr_en;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          idle;

  always #10 clk_50m = ~clk_50m;

  uart_tx_fifo #(.DEPTH(DEPTH), .BUSY_TIMEOUT(4)) dut (
    .clk_50m      (clk_50m),
    .rst_n        (rst_n),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .flush        (flush),
    .uart_din     (uart_din),
    .uart_wr_en   (uart_wr_en),
    .uart_tx_busy (uart_tx_busy),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .idle         (idle)
  );

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] pend_data, exp_byte, din_last, last_din;
  bit   pend_push, pend_flush, pend_ovf, ovf_m, prev_wr_en, fell;
  int   cyc, pulse_count, last_pulse, last_gap, fall_cycle;
  bit   respond = 1'b1;
  bit   hold_busy = 1'b0;
  bit   hold_q, frame_busy;
  int   tx_delay = 1;
  int   tx_frame = 10;
  int   wait_cnt, frame_cnt;

  // Scoreboard first (sees the values the DUT sampled at the last posedge), then the transmitter model.
  always @(negedge clk_50m) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      pend_push = 0; pend_flush = 0; pend_ovf = 0; ovf_m = 0; prev_wr_en = 0;
      din_last = uart_din;
    end else begin
      if (pend_flush) begin
        exp_q.delete();
        ovf_m = 0;
      end else if (pend_ovf) begin
        ovf_m = 1;
      end
      if (uart_wr_en) begin
        if (exp_q.size() == 0) checkOutput("launch_unexpected", 1, 0);
        else begin
          exp_byte = exp_q.pop_front();
          checkOutput("launch_din", uart_din, exp_byte);
        end
        checkOutput("launch_not_consecutive", prev_wr_en, 0);
        checkOutput("launch_busy_low", uart_tx_busy, 0);
        if (fell) checkOutput("launch_gap_ge2", (cyc - fall_cycle >= 2), 1);
        fell = 0;
        if (pulse_count > 0) last_gap = cyc - last_pulse;
        last_pulse = cyc;
        last_din = uart_din;
        pulse_count++;
      end else if (uart_tx_busy) begin
        checkOutput("din_stable_busy", uart_din, din_last);
      end
      if (pend_push && !pend_flush) exp_q.push_back(pend_data);
      checkOutput("count", count, exp_q.size());
      checkOutput("empty", empty, exp_q.size() == 0);
      checkOutput("full", full, exp_q.size() == DEPTH);
      checkOutput("wr_ready", wr_ready, exp_q.size() != DEPTH);
      checkOutput("overflow", overflow, ovf_m);
      pend_flush = flush;
      pend_push  = wr_valid && (exp_q.size() < DEPTH) && !flush;
      pend_ovf   = wr_valid && (exp_q.size() == DEPTH);
      pend_data  = wr_data;
      prev_wr_en = uart_wr_en;
      din_last   = uart_din;
    end
    hold_q = hold_busy;
    if (uart_wr_en && respond) wait_cnt = tx_delay;
    else if (wait_cnt > 0) begin
      wait_cnt--;
      if (wait_cnt == 0) begin
        frame_busy = 1;
        frame_cnt = tx_frame;
      end
    end else if (frame_busy) begin
      frame_cnt--;
      if (frame_cnt == 0) begin
        frame_busy = 0;
        fall_cycle = cyc;
        fell = 1;
      end
    end
    uart_tx_busy = frame_busy | hold_q;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk_50m);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic f);
    wr_valid = v;
    wr_data  = d;
    flush    = f;
    @(posedge clk_50m);
    #1;
    wr_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic waitPulses(input int target, input int budget, input string tag);
    int n = 0;
    while (pulse_count < target && n < budget) begin
      waitCycles(1);
      n++;
    end
    checkOutput(tag, pulse_count >= target, 1);
  endtask

  task automatic waitQuiet(input int budget, input string tag);
    int n = 0;
    while (!(exp_q.size() == 0 && !uart_tx_busy && wait_cnt == 0) && n < budget) begin
      waitCycles(1);
      n++;
    end
    waitCycles(8);
    checkOutput({tag, "_idle"}, idle, 1);
  endtask

  int p0;

  initial begin
    $display("[TB] start");
    waitCycles(2);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_wr_ready", wr_ready, 1);
    checkOutput("rst_wr_en", uart_wr_en, 0);
    checkOutput("rst_din", uart_din, 8'h00);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_idle", idle, 1);
    rst_n = 1'b1;
    waitCycles(2);

    p0 = pulse_count;
    applyStimulus(1, 8'hA5, 0);
    waitPulses(p0 + 1, 20, "t1_pulse");
    checkOutput("t1_din", last_din, 8'hA5);
    waitQuiet(60, "t1");
    checkOutput("t1_pulses", pulse_count, p0 + 1);

    p0 = pulse_count;
    applyStimulus(1, 8'h01, 0);
    applyStimulus(1, 8'h02, 0);
    applyStimulus(1, 8'h03, 0);
    waitPulses(p0 + 3, 150, "t2_pulses");
    checkOutput("t2_last_din", last_din, 8'h03);
    waitQuiet(60, "t2");

    hold_busy = 1'b1;
    waitCycles(2);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 8'h10 + 8'(i), 0);
    checkOutput("t3_count_full", count, DEPTH);
    checkOutput("t3_full", full, 1);
    checkOutput("t3_wr_ready", wr_ready, 0);
    checkOutput("t3_no_ovf_yet", overflow, 0);
    applyStimulus(1, 8'hEE, 0);
    checkOutput("t3_overflow", overflow, 1);
    checkOutput("t3_count_kept", count, DEPTH);
    p0 = pulse_count;
    tx_frame = 3;
    hold_busy = 1'b0;
    waitPulses(p0 + DEPTH, 400, "t3_drain");
    checkOutput("t3_last_din", last_din, 8'h1F);
    waitQuiet(100, "t3");
    checkOutput("t3_no_extra", pulse_count, p0 + DEPTH);

    respond = 1'b0;
    p0 = pulse_count;
    applyStimulus(1, 8'h41, 0);
    applyStimulus(1, 8'h42, 0);
    waitPulses(p0 + 2, 60, "t4_pulses");
    checkOutput("t4_gap", last_gap, 6);
    checkOutput("t4_last_din", last_din, 8'h42);
    waitQuiet(60, "t4");
    respond = 1'b1;

    checkOutput("t5_ovf_before", overflow, 1);
    tx_frame = 10;
    p0 = pulse_count;
    for (int i = 0; i < 5; i++) applyStimulus(1, 8'h51 + 8'(i), 0);
    for (int n = 0; n < 30 && !frame_busy; n++) waitCycles(1);
    checkOutput("t5_busy_seen", frame_busy, 1);
    waitCycles(1);
    applyStimulus(0, 8'h00, 1);
    checkOutput("t5_count", count, 0);
    checkOutput("t5_ovf_cleared", overflow, 0);
    waitCycles(40);
    checkOutput("t5_pulses", pulse_count, p0 + 1);
    checkOutput("t5_idle", idle, 1);

    tx_frame = 20;
    p0 = pulse_count;
    for (int i = 0; i < 4; i++) applyStimulus(1, 8'h61 + 8'(i), 0);
    for (int n = 0; n < 30 && !frame_busy; n++) waitCycles(1);
    waitCycles(2);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("t6_wr_en", uart_wr_en, 0);
    checkOutput("t6_din", uart_din, 8'h00);
    checkOutput("t6_count", count, 0);
    checkOutput("t6_empty", empty, 1);
    checkOutput("t6_wr_ready", wr_ready, 1);
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(40);
    checkOutput("t6_no_pulse", pulse_count, p0 + 1);
    applyStimulus(1, 8'h5A, 0);
    waitPulses(p0 + 2, 40, "t6_new_pulse");
    checkOutput("t6_new_din", last_din, 8'h5A);
    waitQuiet(100, "t6");

    for (int i = 0; i < 400; i++) begin
      tx_frame = $urandom_range(2, 6);
      tx_delay = $urandom_range(1, 2);
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 39) == 0));
    end
    waitQuiet(2000, "rand");
    checkOutput("rand_count", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
